one_wire_seq_ctrl: RTL and testbench
====================================

// Module: one_wire_seq_ctrl
// PURPOSE
//  Sequencer and round-robin arbiter that shares one 1-Wire transceiver (TX+RX pair) between NREQ requesters.
//  Per granted transaction: presence check, ROM command byte, then req_len payload bytes, then a completion.
//  Sits above the transceiver top and drives its start/tx_byte; RX bytes are tagged with the grantee id.
// PARAMETERS
//  NREQ     2     number of requesters (>=2)
//  LEN_W    4     width of payload byte count (max 2**LEN_W-1 bytes)
//  PRES_TO  1024  cycles to wait for presence_detect before error
//  WDOG_TO  65535 cycles allowed per byte for ow_done (only with ONE_WIRE_SEQ_WDOG_EN)
// PORTS
//  clk          in   1            system clock
//  rst          in   1            asynchronous reset, active-high
//  req_valid    in   NREQ         request pending; held until matching cpl_valid
//  req_rom      in   8*NREQ       ROM command byte per requester, slice i = [8i+7:8i]
//  req_len      in   LEN_W*NREQ   payload byte count per requester
//  grant_id     out  IDW          current grantee, IDW=$clog2(NREQ)
//  grant_act    out  1            transaction in progress
//  wr_data      in   8            payload byte from grantee
//  wr_valid     in   1            wr_data valid
//  wr_ready     out  1            1-cycle pulse: wr_data consumed
//  cpl_valid    out  1            1-cycle completion pulse
//  cpl_id       out  IDW          requester completed
//  cpl_err      out  2            0 ok, 1 no presence, 2 byte timeout
//  rd_valid     out  1            received byte pulse
//  rd_byte      out  8            received byte
//  rd_id        out  IDW          grantee at time of receipt
//  ow_start     out  1            1-cycle start pulse to transceiver TX
//  ow_tx_byte   out  8            byte to transmit, stable while ow_busy
//  ow_busy      in   1            transceiver TX busy
//  ow_done      in   1            transceiver TX byte done pulse
//  ow_rx_en     out  1            transceiver RX enable
//  ow_presence  in   1            presence detected
//  ow_rx_valid  in   1            RX byte valid
//  ow_rx_byte   in   8            RX byte
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, round-robin pointer 0, counters 0. Reset mid-transaction aborts without cpl.
//  FSM: IDLE->ARB->PRES->SEND->WAIT->(SEND|CPL)->IDLE.
//  IDLE: any req_valid -> ARB. ARB (1 cycle): first set req_valid at or after pointer wins; latch id, rom, len; grant_act=1.
//  PRES: ow_rx_en=1 (held until CPL). ow_presence=1 -> SEND idx=0; PRES_TO cycles elapsed -> CPL err=1.
//  SEND: issue only when ow_busy=0. idx=0: ow_tx_byte=rom. idx>=1: wait wr_valid; wr_ready pulses same cycle as ow_start.
//  WAIT: on ow_done: idx==len -> CPL, else idx+1 -> SEND. len=0 sends ROM byte only.
//  CPL: cpl_valid=1 one cycle with cpl_id/cpl_err; pointer=id+1 mod NREQ; grant_act=0, ow_rx_en=0 -> IDLE.
//  Latency: req_valid -> ow_start >= 3 cycles (ARB, PRES min 1, SEND). Back-to-back grants need 1 IDLE cycle.
//  RX: rd_valid/rd_byte registered from ow_rx_valid/ow_rx_byte (1 cycle) when grant_act=1; dropped in IDLE. rd_id=grant_id.
//  req_valid dropping mid-transaction is ignored; transaction runs to cpl.
//  ow_done outside WAIT is ignored. idx counter LEN_W bits, no wrap (bounded by len).
// CONFIGURATION
//  ONE_WIRE_SEQ_WDOG_EN defined: WAIT counts cycles; WDOG_TO reached without ow_done -> CPL err=2; counter clears per byte.
//  Undefined: no watchdog, WAIT blocks until ow_done; cpl_err never 2.
// STRUCTURE
//  Package one_wire_pkg: FSM state enum, cpl_err codes (ERR_OK/ERR_NOPRES/ERR_TMO), ROM opcode constants.
//  Sub-module one_wire_rr_arb: NREQ round-robin priority pick, pointer in, id+hit out.
// TESTING
//  1 NREQ=2, req0 rom=0xCC len=2 data 0x44,0xA5, presence at cycle 5 -> ow_tx_byte 0xCC,0x44,0xA5; cpl id0 err0.
//  2 req0,req1 both valid from reset -> grant 0 then 1; with both re-asserted -> order 1... wait, ptr=0 again ->0,1 alternate.
//  3 no ow_presence for PRES_TO cycles -> cpl err=1, zero ow_start pulses, wr_ready never asserted.
//  4 len=0 rom=0x33, ow_rx_valid bytes 0x28,0x01 during grant -> rd_valid x2, rd_id=grantee; byte in IDLE dropped.
//  5 wr_valid low 20 cycles at idx1 -> no ow_start until wr_valid; ow_busy high blocks start until low.
//  6 rst pulse mid-WAIT -> outputs 0 next edge, no cpl; WDOG_EN build: withhold ow_done -> cpl err=2 after WDOG_TO.

Source files
------------

// File: rtl/one_wire_pkg.sv
// Shared state, completion-code and ROM opcode definitions for the 1-Wire sequencer.
package one_wire_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_PRES,
      ST_SEND,
      ST_WAIT,
      ST_CPL
   } seq_state_e;

   localparam logic [1:0] ERR_OK     = 2'd0;
   localparam logic [1:0] ERR_NOPRES = 2'd1;
   localparam logic [1:0] ERR_TMO    = 2'd2;

   localparam logic [7:0] ROM_READ  = 8'h33;
   localparam logic [7:0] ROM_MATCH = 8'h55;
   localparam logic [7:0] ROM_SKIP  = 8'hCC;

endpackage

// File: rtl/one_wire_rr_arb.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping modulo NREQ.
module one_wire_rr_arb #(
   parameter int unsigned NREQ = 2
) (
   input  logic [NREQ-1:0]          req_i,
   input  logic [$clog2(NREQ)-1:0]  ptr_i,
   output logic [$clog2(NREQ)-1:0]  id_c_o,
   output logic                     hit_c_o
);
   localparam int unsigned IDW = $clog2(NREQ);

   int unsigned cand;

   always_comb begin
      id_c_o  = '0;
      hit_c_o = 1'b0;
      cand    = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = (32'(ptr_i) + k) % NREQ;
         if (!hit_c_o && req_i[IDW'(cand)]) begin
            hit_c_o = 1'b1;
            id_c_o  = IDW'(cand);
         end
      end
   end

endmodule

// File: rtl/one_wire_seq_ctrl.sv
// Sequencer + round-robin arbiter sharing one 1-Wire transceiver among NREQ requesters.
// Optional per-byte ow_done watchdog enabled by defining ONE_WIRE_SEQ_WDOG_EN.
module one_wire_seq_ctrl
   import one_wire_pkg::*;
#(
   parameter int unsigned NREQ    = 2,
   parameter int unsigned LEN_W   = 4,
   parameter int unsigned PRES_TO = 1024,
   parameter int unsigned WDOG_TO = 65535
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid_i,
   input  logic [8*NREQ-1:0]         req_rom_i,
   input  logic [LEN_W*NREQ-1:0]     req_len_i,
   output logic [$clog2(NREQ)-1:0]   grant_id_o,
   output logic                      grant_act_o,
   input  logic [7:0]                wr_data_i,
   input  logic                      wr_valid_i,
   output logic                      wr_ready_o,
   output logic                      cpl_valid_o,
   output logic [$clog2(NREQ)-1:0]   cpl_id_o,
   output logic [1:0]                cpl_err_o,
   output logic                      rd_valid_o,
   output logic [7:0]                rd_byte_o,
   output logic [$clog2(NREQ)-1:0]   rd_id_o,
   output logic                      ow_start_o,
   output logic [7:0]                ow_tx_byte_o,
   input  logic                      ow_busy_i,
   input  logic                      ow_done_i,
   output logic                      ow_rx_en_o,
   input  logic                      ow_presence_i,
   input  logic                      ow_rx_valid_i,
   input  logic [7:0]                ow_rx_byte_i
);
   localparam int unsigned IDW     = $clog2(NREQ);
   localparam int unsigned CNT_MAX = (PRES_TO > WDOG_TO) ? PRES_TO : WDOG_TO;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   seq_state_e        state_q, state_d;
   logic [IDW-1:0]    id_q, id_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [7:0]        rom_q, rom_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        err_q, err_d;
   logic              grant_act_q, grant_act_d;
   logic              wr_ready_q, wr_ready_d;
   logic              cpl_valid_q, cpl_valid_d;
   logic [IDW-1:0]    cpl_id_q, cpl_id_d;
   logic [1:0]        cpl_err_q, cpl_err_d;
   logic              rd_valid_q, rd_valid_d;
   logic [7:0]        rd_byte_q, rd_byte_d;
   logic [IDW-1:0]    rd_id_q, rd_id_d;
   logic              ow_start_q, ow_start_d;
   logic [7:0]        ow_tx_byte_q, ow_tx_byte_d;
   logic              ow_rx_en_q, ow_rx_en_d;

   logic [IDW-1:0]    win_id_c;
   logic              win_hit_c;

   one_wire_rr_arb #(.NREQ(NREQ)) u_arb (
      .req_i   (req_valid_i),
      .ptr_i   (ptr_q),
      .id_c_o  (win_id_c),
      .hit_c_o (win_hit_c)
   );

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      id_d         = id_q;
      ptr_d        = ptr_q;
      rom_d        = rom_q;
      len_d        = len_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      grant_act_d  = grant_act_q;
      ow_rx_en_d   = ow_rx_en_q;
      ow_tx_byte_d = ow_tx_byte_q;
      cpl_id_d     = cpl_id_q;
      cpl_err_d    = cpl_err_q;
      ow_start_d   = 1'b0;
      wr_ready_d   = 1'b0;
      cpl_valid_d  = 1'b0;
      rd_valid_d   = ow_rx_valid_i & grant_act_q;
      rd_byte_d    = rd_byte_q;
      rd_id_d      = rd_id_q;

      // RX bytes are only forwarded while a grant is live
      if (ow_rx_valid_i && grant_act_q) begin
         rd_byte_d = ow_rx_byte_i;
         rd_id_d   = id_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (|req_valid_i) state_d = ST_ARB;
         end
         ST_ARB: begin
            if (win_hit_c) begin
               id_d        = win_id_c;
               rom_d       = req_rom_i[32'(win_id_c)*8 +: 8];
               len_d       = req_len_i[32'(win_id_c)*LEN_W +: LEN_W];
               idx_d       = '0;
               cnt_d       = '0;
               err_d       = ERR_OK;
               grant_act_d = 1'b1;
               ow_rx_en_d  = 1'b1;
               state_d     = ST_PRES;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PRES: begin
            if (ow_presence_i) begin
               idx_d   = '0;
               state_d = ST_SEND;
            end else if (cnt_q == CNT_W'(PRES_TO - 1)) begin
               err_d   = ERR_NOPRES;
               state_d = ST_CPL;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_SEND: begin
            // idx 0 is the ROM command; payload bytes need the grantee's data
            if (!ow_busy_i) begin
               if (idx_q == '0) begin
                  ow_start_d   = 1'b1;
                  ow_tx_byte_d = rom_q;
                  cnt_d        = '0;
                  state_d      = ST_WAIT;
               end else if (wr_valid_i) begin
                  ow_start_d   = 1'b1;
                  wr_ready_d   = 1'b1;
                  ow_tx_byte_d = wr_data_i;
                  cnt_d        = '0;
                  state_d      = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (ow_done_i) begin
               if (idx_q == len_q) begin
                  state_d = ST_CPL;
               end else begin
                  idx_d   = idx_q + LEN_W'(1);
                  state_d = ST_SEND;
               end
            end
`ifdef ONE_WIRE_SEQ_WDOG_EN
            else if (cnt_q == CNT_W'(WDOG_TO - 1)) begin
               err_d   = ERR_TMO;
               state_d = ST_CPL;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         ST_CPL: begin
            cpl_valid_d = 1'b1;
            cpl_id_d    = id_q;
            cpl_err_d   = err_q;
            ptr_d       = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
            grant_act_d = 1'b0;
            ow_rx_en_d  = 1'b0;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         id_q         <= '0;
         ptr_q        <= '0;
         rom_q        <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         cnt_q        <= '0;
         err_q        <= ERR_OK;
         grant_act_q  <= 1'b0;
         wr_ready_q   <= 1'b0;
         cpl_valid_q  <= 1'b0;
         cpl_id_q     <= '0;
         cpl_err_q    <= ERR_OK;
         rd_valid_q   <= 1'b0;
         rd_byte_q    <= '0;
         rd_id_q      <= '0;
         ow_start_q   <= 1'b0;
         ow_tx_byte_q <= '0;
         ow_rx_en_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         id_q         <= id_d;
         ptr_q        <= ptr_d;
         rom_q        <= rom_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         grant_act_q  <= grant_act_d;
         wr_ready_q   <= wr_ready_d;
         cpl_valid_q  <= cpl_valid_d;
         cpl_id_q     <= cpl_id_d;
         cpl_err_q    <= cpl_err_d;
         rd_valid_q   <= rd_valid_d;
         rd_byte_q    <= rd_byte_d;
         rd_id_q      <= rd_id_d;
         ow_start_q   <= ow_start_d;
         ow_tx_byte_q <= ow_tx_byte_d;
         ow_rx_en_q   <= ow_rx_en_d;
      end
   end

   assign grant_id_o   = id_q;
   assign grant_act_o  = grant_act_q;
   assign wr_ready_o   = wr_ready_q;
   assign cpl_valid_o  = cpl_valid_q;
   assign cpl_id_o     = cpl_id_q;
   assign cpl_err_o    = cpl_err_q;
   assign rd_valid_o   = rd_valid_q;
   assign rd_byte_o    = rd_byte_q;
   assign rd_id_o      = rd_id_q;
   assign ow_start_o   = ow_start_q;
   assign ow_tx_byte_o = ow_tx_byte_q;
   assign ow_rx_en_o   = ow_rx_en_q;

endmodule

// File: tb/tb_one_wire_seq_ctrl.sv
// Scoreboard bench for one_wire_seq_ctrl: transceiver/requester models feed expected-result queues.
module tb_one_wire_seq_ctrl;
   import one_wire_pkg::*;

   localparam int unsigned NREQ     = 2;
   localparam int unsigned LEN_W    = 4;
   localparam int unsigned PRES_TO  = 100;
   localparam int unsigned WDOG_TO  = 300;
   localparam int unsigned BUSY_LEN = 4;

   typedef struct packed { logic [7:0] b; logic [0:0] id; } tag_t;
   typedef struct packed { logic [0:0] id; logic [1:0] err; } cpl_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [8*NREQ-1:0]     req_rom;
   logic [LEN_W*NREQ-1:0] req_len;
   logic [0:0]            grant_id;
   logic                  grant_act;
   logic [7:0]            wr_data;
   logic                  wr_valid;
   logic                  wr_ready;
   logic                  cpl_valid;
   logic [0:0]            cpl_id;
   logic [1:0]            cpl_err;
   logic                  rd_valid;
   logic [7:0]            rd_byte;
   logic [0:0]            rd_id;
   logic                  ow_start;
   logic [7:0]            ow_tx_byte;
   logic                  ow_busy;
   logic                  ow_done;
   logic                  ow_rx_en;
   logic                  ow_presence;
   logic                  ow_rx_valid;
   logic [7:0]            ow_rx_byte;

   tag_t       tx_q[$];
   tag_t       rd_q[$];
   cpl_t       cpl_q[$];
   logic [7:0] wr_q[$];

   int checks = 0, errors = 0;
   int start_cnt = 0, wrrdy_cnt = 0, cpl_cnt = 0, done_cnt = 0, rd_cnt = 0;
   bit done_en = 1'b1, pres_en = 1'b1, wr_gate = 1'b1, hold_busy = 1'b0;
   int pres_delay = 0;
   logic model_busy = 1'b0;

   assign ow_busy = model_busy | hold_busy;

   always #5 clk = ~clk;

   one_wire_seq_ctrl #(
      .NREQ(NREQ), .LEN_W(LEN_W), .PRES_TO(PRES_TO), .WDOG_TO(WDOG_TO)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_rom_i(req_rom), .req_len_i(req_len),
      .grant_id_o(grant_id), .grant_act_o(grant_act),
      .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
      .cpl_valid_o(cpl_valid), .cpl_id_o(cpl_id), .cpl_err_o(cpl_err),
      .rd_valid_o(rd_valid), .rd_byte_o(rd_byte), .rd_id_o(rd_id),
      .ow_start_o(ow_start), .ow_tx_byte_o(ow_tx_byte),
      .ow_busy_i(ow_busy), .ow_done_i(ow_done), .ow_rx_en_o(ow_rx_en),
      .ow_presence_i(ow_presence), .ow_rx_valid_i(ow_rx_valid), .ow_rx_byte_i(ow_rx_byte)
   );

   // Transceiver TX: busy for BUSY_LEN cycles after each start, then a done pulse
   initial begin
      ow_done = 1'b0;
      forever begin
         @(posedge clk); #1;
         ow_done = 1'b0;
         if (ow_start && !rst) begin
            model_busy = 1'b1;
            repeat (BUSY_LEN) @(posedge clk);
            #1;
            if (done_en) ow_done = 1'b1;
            model_busy = 1'b0;
         end
      end
   end

   // Presence appears pres_delay cycles after RX enable when allowed
   initial begin
      int pres_cyc;
      pres_cyc    = 0;
      ow_presence = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (ow_rx_en) begin
            pres_cyc++;
            ow_presence = pres_en && (pres_cyc > pres_delay);
         end else begin
            pres_cyc    = 0;
            ow_presence = 1'b0;
         end
      end
   end

   // Grantee write-data driver
   initial begin
      wr_valid = 1'b0;
      wr_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            wr_valid = 1'b0;
         end else begin
            if (wr_ready && wr_q.size() > 0) void'(wr_q.pop_front());
            wr_valid = wr_gate && (wr_q.size() > 0);
            wr_data  = wr_valid ? wr_q[0] : 8'h00;
         end
      end
   end

   // Output monitor / scoreboard
   initial begin
      tag_t et;
      cpl_t ec;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (ow_done) done_cnt++;
            if (ow_start) begin
               start_cnt++;
               checks++;
               if (tx_q.size() == 0) begin
                  errors++;
                  $display("FAIL tx_unexpected: got byte %02h id %0d, none expected", ow_tx_byte, grant_id);
               end else begin
                  et = tx_q.pop_front();
                  if ({ow_tx_byte, grant_id} !== {et.b, et.id}) begin
                     errors++;
                     $display("FAIL tx_byte: got %02h id %0d, expected %02h id %0d", ow_tx_byte, grant_id, et.b, et.id);
                  end
               end
            end
            if (wr_ready) begin
               wrrdy_cnt++;
               checks++;
               if (ow_start !== 1'b1) begin
                  errors++;
                  $display("FAIL wr_ready_align: ow_start=%b with wr_ready, expected 1", ow_start);
               end
            end
            if (cpl_valid) begin
               cpl_cnt++;
               checks++;
               req_valid[cpl_id] = 1'b0;
               if (cpl_q.size() == 0) begin
                  errors++;
                  $display("FAIL cpl_unexpected: got id %0d err %0d, none expected", cpl_id, cpl_err);
               end else begin
                  ec = cpl_q.pop_front();
                  if ({cpl_id, cpl_err} !== {ec.id, ec.err}) begin
                     errors++;
                     $display("FAIL cpl: got id %0d err %0d, expected id %0d err %0d", cpl_id, cpl_err, ec.id, ec.err);
                  end
               end
            end
            if (rd_valid) begin
               rd_cnt++;
               checks++;
               if (rd_q.size() == 0) begin
                  errors++;
                  $display("FAIL rd_unexpected: got %02h id %0d, none expected", rd_byte, rd_id);
               end else begin
                  et = rd_q.pop_front();
                  if ({rd_byte, rd_id} !== {et.b, et.id}) begin
                     errors++;
                     $display("FAIL rd: got %02h id %0d, expected %02h id %0d", rd_byte, rd_id, et.b, et.id);
                  end
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation ran past 1ms, expected completion");
      $fatal(1, "timeout");
   end

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      wr_gate = 1'b1; hold_busy = 1'b0; done_en = 1'b1; pres_en = 1'b1; pres_delay = 0;
      ow_rx_valid = 1'b0; ow_rx_byte = 8'h00;
      tx_q.delete(); rd_q.delete(); cpl_q.delete(); wr_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 2'b11;
      repeat (2) @(negedge clk);
      checks++;
      if ({grant_act, ow_start, wr_ready, cpl_valid, rd_valid, ow_rx_en, grant_id, cpl_err, ow_tx_byte, rd_byte} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got nonzero outputs during reset, expected all 0");
      end
      do_reset();
      checks++;
      if ({grant_act, ow_start, cpl_valid, ow_rx_en} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle: got act/start/cpl/rxen=%b%b%b%b, expected 0000", grant_act, ow_start, cpl_valid, ow_rx_en);
      end
   endtask

   task automatic test_basic();
      int n0, s0, w0, lat;
      n0 = cpl_cnt; s0 = start_cnt; w0 = wrrdy_cnt; lat = -1;
      pres_delay = 5;
      req_rom[7:0] = ROM_SKIP; req_len[3:0] = 4'd2;
      wr_q.push_back(8'h44); wr_q.push_back(8'hA5);
      tx_q.push_back('{8'hCC, 1'b0}); tx_q.push_back('{8'h44, 1'b0}); tx_q.push_back('{8'hA5, 1'b0});
      cpl_q.push_back('{1'b0, ERR_OK});
      req_valid[0] = 1'b1;
      for (int i = 0; i < 600 && cpl_cnt == n0; i++) begin
         @(negedge clk);
         if (lat < 0 && start_cnt != s0) lat = i + 1;
      end
      checks++;
      if (cpl_cnt == n0) begin errors++; $display("FAIL basic_cpl_timeout: no completion, expected one"); end
      checks++;
      if (lat < 3 || lat > 12) begin errors++; $display("FAIL basic_latency: got %0d cycles, expected 3..12", lat); end
      checks++;
      if (wrrdy_cnt - w0 != 2) begin errors++; $display("FAIL basic_wr_ready: got %0d pulses, expected 2", wrrdy_cnt - w0); end
      checks++;
      if (tx_q.size() != 0 || cpl_q.size() != 0) begin errors++; $display("FAIL basic_drain: got %0d tx %0d cpl pending, expected 0", tx_q.size(), cpl_q.size()); end
      pres_delay = 0;
   endtask

   task automatic test_rr();
      int n0;
      do_reset();
      req_rom = {ROM_MATCH, ROM_SKIP}; req_len = {4'd1, 4'd1};
      for (int r = 0; r < 2; r++) begin
         n0 = cpl_cnt;
         wr_q.push_back(8'h11 + 8'(r)); wr_q.push_back(8'h22 + 8'(r));
         tx_q.push_back('{8'hCC, 1'b0}); tx_q.push_back('{8'h11 + 8'(r), 1'b0});
         tx_q.push_back('{8'h55, 1'b1}); tx_q.push_back('{8'h22 + 8'(r), 1'b1});
         cpl_q.push_back('{1'b0, ERR_OK}); cpl_q.push_back('{1'b1, ERR_OK});
         req_valid = 2'b11;
         for (int i = 0; i < 600 && cpl_cnt < n0 + 2; i++) @(negedge clk);
         checks++;
         if (cpl_cnt != n0 + 2) begin errors++; $display("FAIL rr_cpl_count round %0d: got %0d, expected 2", r, cpl_cnt - n0); end
      end
      checks++;
      if (tx_q.size() != 0 || cpl_q.size() != 0) begin errors++; $display("FAIL rr_drain: got %0d tx %0d cpl pending, expected 0", tx_q.size(), cpl_q.size()); end
   endtask

   task automatic test_nopres();
      int n0, s0, w0, act;
      n0 = cpl_cnt; s0 = start_cnt; w0 = wrrdy_cnt; act = 0;
      pres_en = 1'b0;
      req_len[3:0] = 4'd2;
      wr_q.push_back(8'h01); wr_q.push_back(8'h02);
      cpl_q.push_back('{1'b0, ERR_NOPRES});
      req_valid[0] = 1'b1;
      for (int i = 0; i < PRES_TO + 50 && cpl_cnt == n0; i++) begin
         @(negedge clk);
         if (grant_act) act++;
      end
      checks++;
      if (cpl_cnt == n0) begin errors++; $display("FAIL nopres_cpl_timeout: no completion, expected err 1"); end
      checks++;
      if (start_cnt != s0 || wrrdy_cnt != w0) begin errors++; $display("FAIL nopres_quiet: got %0d starts %0d wr_ready, expected 0 0", start_cnt - s0, wrrdy_cnt - w0); end
      checks++;
      if (act < int'(PRES_TO) || act > int'(PRES_TO) + 2) begin errors++; $display("FAIL nopres_window: got %0d grant cycles, expected %0d..%0d", act, PRES_TO, PRES_TO + 2); end
      wr_q.delete();
      pres_en = 1'b1;
   endtask

   task automatic test_rx();
      int n0, r0;
      n0 = cpl_cnt; r0 = rd_cnt;
      req_rom[15:8] = ROM_READ; req_len[7:4] = 4'd0;
      tx_q.push_back('{ROM_READ, 1'b1});
      cpl_q.push_back('{1'b1, ERR_OK});
      rd_q.push_back('{8'h28, 1'b1}); rd_q.push_back('{8'h01, 1'b1});
      req_valid[1] = 1'b1;
      for (int i = 0; i < 50 && !grant_act; i++) @(negedge clk);
      ow_rx_valid = 1'b1; ow_rx_byte = 8'h28;
      @(negedge clk);
      ow_rx_byte = 8'h01;
      @(negedge clk);
      ow_rx_valid = 1'b0;
      for (int i = 0; i < 100 && cpl_cnt == n0; i++) @(negedge clk);
      checks++;
      if (cpl_cnt == n0) begin errors++; $display("FAIL rx_cpl_timeout: no completion, expected one"); end
      ow_rx_valid = 1'b1; ow_rx_byte = 8'h77;
      @(negedge clk);
      ow_rx_valid = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (rd_cnt - r0 != 2) begin errors++; $display("FAIL rx_count: got %0d rd pulses, expected 2", rd_cnt - r0); end
   endtask

   task automatic test_stall();
      int n0, d0, s1, w1;
      n0 = cpl_cnt; d0 = done_cnt;
      req_rom[7:0] = ROM_SKIP; req_len[3:0] = 4'd1;
      wr_gate = 1'b0;
      wr_q.push_back(8'h5A);
      tx_q.push_back('{8'hCC, 1'b0}); tx_q.push_back('{8'h5A, 1'b0});
      cpl_q.push_back('{1'b0, ERR_OK});
      req_valid[0] = 1'b1;
      for (int i = 0; i < 100 && done_cnt == d0; i++) @(negedge clk);
      s1 = start_cnt; w1 = wrrdy_cnt;
      repeat (20) @(negedge clk);
      checks++;
      if (start_cnt != s1) begin errors++; $display("FAIL stall_no_wr: got %0d starts while wr_valid low, expected 0", start_cnt - s1); end
      hold_busy = 1'b1; wr_gate = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (start_cnt != s1 || wrrdy_cnt != w1) begin errors++; $display("FAIL stall_busy: got %0d starts %0d wr_ready while busy, expected 0 0", start_cnt - s1, wrrdy_cnt - w1); end
      hold_busy = 1'b0;
      for (int i = 0; i < 100 && cpl_cnt == n0; i++) @(negedge clk);
      checks++;
      if (cpl_cnt == n0 || wrrdy_cnt - w1 != 1) begin errors++; $display("FAIL stall_release: got cpl %0d wr_ready %0d, expected 1 1", cpl_cnt - n0, wrrdy_cnt - w1); end
   endtask

   task automatic test_reset_mid();
      int n0, s0;
      n0 = cpl_cnt; s0 = start_cnt;
      req_rom[7:0] = ROM_SKIP; req_len[3:0] = 4'd3;
      wr_q.push_back(8'h01); wr_q.push_back(8'h02); wr_q.push_back(8'h03);
      tx_q.push_back('{8'hCC, 1'b0});
      req_valid[0] = 1'b1;
      for (int i = 0; i < 100 && start_cnt == s0; i++) @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({grant_act, ow_start, wr_ready, cpl_valid, rd_valid, ow_rx_en, ow_tx_byte} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got act=%b rxen=%b tx=%02h, expected all 0", grant_act, ow_rx_en, ow_tx_byte);
      end
      req_valid = '0;
      tx_q.delete(); wr_q.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (cpl_cnt != n0) begin errors++; $display("FAIL midreset_no_cpl: got %0d completions, expected 0", cpl_cnt - n0); end
   endtask

`ifdef ONE_WIRE_SEQ_WDOG_EN
   task automatic test_wdog();
      int n0, w0;
      n0 = cpl_cnt; w0 = wrrdy_cnt;
      done_en = 1'b0;
      req_rom[7:0] = ROM_SKIP; req_len[3:0] = 4'd1;
      wr_q.push_back(8'h99);
      tx_q.push_back('{8'hCC, 1'b0});
      cpl_q.push_back('{1'b0, ERR_TMO});
      req_valid[0] = 1'b1;
      for (int i = 0; i < WDOG_TO + 100 && cpl_cnt == n0; i++) @(negedge clk);
      checks++;
      if (cpl_cnt == n0 || wrrdy_cnt != w0) begin errors++; $display("FAIL wdog: got cpl %0d wr_ready %0d, expected 1 0", cpl_cnt - n0, wrrdy_cnt - w0); end
      wr_q.delete();
      done_en = 1'b1;
   endtask
`endif

   initial begin
      rst = 1'b1;
      req_valid = '0; req_rom = '0; req_len = '0;
      ow_rx_valid = 1'b0; ow_rx_byte = 8'h00;
      test_reset();
      test_basic();
      test_rr();
      test_nopres();
      test_rx();
      test_stall();
      test_reset_mid();
`ifdef ONE_WIRE_SEQ_WDOG_EN
      test_wdog();
`endif
      checks++;
      if (tx_q.size() != 0 || cpl_q.size() != 0 || rd_q.size() != 0) begin
         errors++;
         $display("FAIL final_drain: got %0d tx %0d cpl %0d rd pending, expected 0", tx_q.size(), cpl_q.size(), rd_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
